// File: rtl/i2s_tx_sequencer.sv
// I2S transmit sequencer: serializes stereo PCM samples into BCLK/LRCLK/SDATA.
// A one-entry valid/ready holding register feeds the shift registers at each
// frame boundary; an empty holding register at a frame load raises underrun.
// Optional build macro: UNDERRUN_REPEAT_EN -- when defined, an underrun frame
// replays the last sample pair that was loaded from the holding register
// instead of sending zeros.
module i2s_tx_sequencer #(
    parameter int SAMPLE_W = 16,
    parameter int BCLK_DIV = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic                sample_valid,
    input  logic [SAMPLE_W-1:0] sample_l,
    input  logic [SAMPLE_W-1:0] sample_r,
    output logic                sample_ready,
    output logic                bclk,
    output logic                lrclk,
    output logic                sdata,
    output logic                underrun,
    output logic                busy
);

    localparam int DIV_W = $clog2(BCLK_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(BCLK_DIV / 2);
    localparam logic [4:0]       SW_LAST  = 5'(SAMPLE_W);
    localparam logic [4:0]       BIT_LAST = 5'd31;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_STOP = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [DIV_W-1:0]     div_cnt_q, div_cnt_d;
    logic [4:0]           bit_cnt_q, bit_cnt_d;
    logic                 lr_q, lr_d;
    logic                 hold_full_q, hold_full_d;
    logic [SAMPLE_W-1:0]  hold_l_q, hold_l_d;
    logic [SAMPLE_W-1:0]  hold_r_q, hold_r_d;
    logic [SAMPLE_W-1:0]  shift_l_q, shift_l_d;
    logic [SAMPLE_W-1:0]  shift_r_q, shift_r_d;
    logic                 sdata_q, sdata_d;
    logic                 bclk_q, bclk_d;
    logic                 lrclk_q, lrclk_d;
    logic                 underrun_q, underrun_d;
    logic                 busy_q, busy_d;
    logic                 sample_ready_q, sample_ready_d;
    logic                 load_s;
    logic                 capture_s;

`ifdef UNDERRUN_REPEAT_EN
    logic [SAMPLE_W-1:0]  last_l_q, last_l_d;
    logic [SAMPLE_W-1:0]  last_r_q, last_r_d;
`endif

    // Bit positions within a channel slot that carry sample data (slot bit 0 is the I2S delay bit).
    function automatic logic in_data_window(input logic [4:0] idx);
        return (idx != 5'd0) && (idx <= SW_LAST);
    endfunction

    // Next-state logic: FSM, BCLK divider, bit/channel counters, serializer and holding register.
    always_comb begin
        state_d    = state_q;
        div_cnt_d  = div_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        lr_d       = lr_q;
        shift_l_d  = shift_l_q;
        shift_r_d  = shift_r_q;
        sdata_d    = sdata_q;
        underrun_d = 1'b0;
        load_s     = 1'b0;
        capture_s  = sample_valid && !hold_full_q;

        case (state_q)
            ST_IDLE: begin
                div_cnt_d = '0;
                bit_cnt_d = 5'd0;
                lr_d      = 1'b0;
                sdata_d   = 1'b0;
                if (enable) begin
                    state_d = ST_RUN;
                    load_s  = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (div_cnt_q == DIV_LAST) begin
                    div_cnt_d = '0;
                    if (lr_q && (bit_cnt_q == BIT_LAST)) begin
                        // Last clk of bit 63: either start the next frame or wind down.
                        bit_cnt_d = 5'd0;
                        lr_d      = 1'b0;
                        sdata_d   = 1'b0;
                        if (enable) begin
                            load_s = 1'b1;
                        end else begin
                            state_d = ST_STOP;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + 5'd1;
                        if (bit_cnt_q == BIT_LAST) begin
                            lr_d = ~lr_q;
                        end else begin
                            lr_d = lr_q;
                        end
                        // Present the current MSB and advance that channel's shifter.
                        if (in_data_window(bit_cnt_d)) begin
                            if (lr_d) begin
                                sdata_d   = shift_r_q[SAMPLE_W-1];
                                shift_r_d = shift_r_q << 1'b1;
                            end else begin
                                sdata_d   = shift_l_q[SAMPLE_W-1];
                                shift_l_d = shift_l_q << 1'b1;
                            end
                        end else begin
                            sdata_d = 1'b0;
                        end
                    end
                end else begin
                    div_cnt_d = div_cnt_q + DIV_W'(1);
                end
            end
            ST_STOP: begin
                state_d   = ST_IDLE;
                div_cnt_d = '0;
                bit_cnt_d = 5'd0;
                lr_d      = 1'b0;
                sdata_d   = 1'b0;
            end
            default: begin
                state_d   = ST_IDLE;
                div_cnt_d = '0;
                bit_cnt_d = 5'd0;
                lr_d      = 1'b0;
                sdata_d   = 1'b0;
            end
        endcase

        // Frame load: take the held pair, or flag an underrun and load the fallback pair.
        if (load_s && hold_full_q) begin
            shift_l_d = hold_l_q;
            shift_r_d = hold_r_q;
        end else if (load_s) begin
            underrun_d = 1'b1;
`ifdef UNDERRUN_REPEAT_EN
            shift_l_d = last_l_q;
            shift_r_d = last_r_q;
`else
            shift_l_d = '0;
            shift_r_d = '0;
`endif
        end else begin
            underrun_d = 1'b0;
        end

        // Holding register: a capture can only happen while empty, a load only drains while full.
        hold_l_d = capture_s ? sample_l : hold_l_q;
        hold_r_d = capture_s ? sample_r : hold_r_q;
        if (capture_s) begin
            hold_full_d = 1'b1;
        end else if (load_s && hold_full_q) begin
            hold_full_d = 1'b0;
        end else begin
            hold_full_d = hold_full_q;
        end
    end

    // Output values derived from next state so every output leaves a flop.
    always_comb begin
        bclk_d         = (state_d == ST_RUN) && (div_cnt_d >= DIV_HALF);
        lrclk_d        = (state_d == ST_RUN) && lr_d;
        busy_d         = (state_d != ST_IDLE);
        sample_ready_d = !hold_full_d;
    end

    // State, counters, datapath and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            div_cnt_q      <= '0;
            bit_cnt_q      <= 5'd0;
            lr_q           <= 1'b0;
            hold_full_q    <= 1'b0;
            hold_l_q       <= '0;
            hold_r_q       <= '0;
            shift_l_q      <= '0;
            shift_r_q      <= '0;
            sdata_q        <= 1'b0;
            bclk_q         <= 1'b0;
            lrclk_q        <= 1'b0;
            underrun_q     <= 1'b0;
            busy_q         <= 1'b0;
            sample_ready_q <= 1'b1;
        end else begin
            state_q        <= state_d;
            div_cnt_q      <= div_cnt_d;
            bit_cnt_q      <= bit_cnt_d;
            lr_q           <= lr_d;
            hold_full_q    <= hold_full_d;
            hold_l_q       <= hold_l_d;
            hold_r_q       <= hold_r_d;
            shift_l_q      <= shift_l_d;
            shift_r_q      <= shift_r_d;
            sdata_q        <= sdata_d;
            bclk_q         <= bclk_d;
            lrclk_q        <= lrclk_d;
            underrun_q     <= underrun_d;
            busy_q         <= busy_d;
            sample_ready_q <= sample_ready_d;
        end
    end

`ifdef UNDERRUN_REPEAT_EN
    // Remember the most recent pair that was actually loaded from the holding register.
    always_comb begin
        if (load_s && hold_full_q) begin
            last_l_d = hold_l_q;
            last_r_d = hold_r_q;
        end else begin
            last_l_d = last_l_q;
            last_r_d = last_r_q;
        end
    end

    // Last-sample registers used as the underrun fallback.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_l_q <= '0;
            last_r_q <= '0;
        end else begin
            last_l_q <= last_l_d;
            last_r_q <= last_r_d;
        end
    end
`endif

    assign sample_ready = sample_ready_q;
    assign bclk         = bclk_q;
    assign lrclk        = lrclk_q;
    assign sdata        = sdata_q;
    assign underrun     = underrun_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_i2s_tx_sequencer.sv
// Self-checking bench for i2s_tx_sequencer (SAMPLE_W=16, BCLK_DIV=4).
// Expected frames are queued as samples are driven; a monitor deserializes
// each 64-bit frame from the pins and compares it with the queue head.
module tb_i2s_tx_sequencer;

    localparam int SW         = 16;
    localparam int DIV        = 4;
    localparam int FRAME_CLKS = 64 * DIV;
    localparam int BUDGET     = 600;
    localparam int NV         = 5;
`ifdef UNDERRUN_REPEAT_EN
    localparam bit REPEAT = 1'b1;
`else
    localparam bit REPEAT = 1'b0;
`endif

    typedef struct packed {
        logic [SW-1:0] l;
        logic [SW-1:0] r;
        logic          present;
        logic          stop;
    } vec_t;

    typedef struct packed {
        logic [SW-1:0] l;
        logic [SW-1:0] r;
        logic          under;
        logic          stop;
    } exp_t;

    logic          clk;
    logic          reset;
    logic          enable;
    logic          sample_valid;
    logic [SW-1:0] sample_l;
    logic [SW-1:0] sample_r;
    logic          sample_ready;
    logic          bclk;
    logic          lrclk;
    logic          sdata;
    logic          underrun;
    logic          busy;

    int            n_checks = 0;
    int            n_errors = 0;
    int            cyc      = 0;
    exp_t          exp_q[$];
    logic [SW-1:0] last_l;
    logic [SW-1:0] last_r;
    vec_t          tbl[NV];

    i2s_tx_sequencer #(.SAMPLE_W(SW), .BCLK_DIV(DIV)) dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .sample_valid (sample_valid),
        .sample_l     (sample_l),
        .sample_r     (sample_r),
        .sample_ready (sample_ready),
        .bclk         (bclk),
        .lrclk        (lrclk),
        .sdata        (sdata),
        .underrun     (underrun),
        .busy         (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic wait_until(input int target);
        while (cyc < target) tick();
    endtask

    // Drive one pair with valid held until the DUT takes it; acc = cycle of the capturing edge.
    task automatic send(input logic [SW-1:0] l, input logic [SW-1:0] r, output int acc);
        sample_valid = 1'b1;
        sample_l     = l;
        sample_r     = r;
        acc          = -1;
        for (int n = 0; n < BUDGET && acc < 0; n++) begin
            if (sample_ready === 1'b1) begin
                tick();
                acc = cyc;
            end else begin
                tick();
            end
        end
        sample_valid = 1'b0;
        if (acc < 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL send_timeout actual=not_accepted required=accepted_within_%0d", BUDGET);
        end
    endtask

    task automatic push_exp(input logic [SW-1:0] l, input logic [SW-1:0] r, input logic u, input logic s);
        exp_t e;
        e.l = l;
        e.r = r;
        e.under = u;
        e.stop = s;
        exp_q.push_back(e);
    endtask

    // Called in the STOP cycle: one clk of STOP with outputs low, then IDLE.
    task automatic check_stop_idle(input string tag);
        chk({tag, "_stop_busy"},     64'(busy),     64'd1);
        chk({tag, "_stop_bclk"},     64'(bclk),     64'd0);
        chk({tag, "_stop_lrclk"},    64'(lrclk),    64'd0);
        chk({tag, "_stop_sdata"},    64'(sdata),    64'd0);
        chk({tag, "_stop_underrun"}, 64'(underrun), 64'd0);
        tick();
        chk({tag, "_idle_busy"},     64'(busy),     64'd0);
        chk({tag, "_idle_bclk"},     64'(bclk),     64'd0);
        chk({tag, "_idle_lrclk"},    64'(lrclk),    64'd0);
        chk({tag, "_idle_underrun"}, 64'(underrun), 64'd0);
    endtask

    task automatic check_frame(input logic [63:0] bits, input logic [63:0] lrs, input logic u0,
                               input int uo, input int bb, output logic stop);
        exp_t          e;
        logic [SW-1:0] l;
        logic [SW-1:0] r;
        int            bad_zero;
        int            bad_lr;
        stop = 1'b0;
        l = '0;
        r = '0;
        if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL frame_scoreboard actual=empty required=entry");
        end else begin
            e = exp_q.pop_front();
            stop = e.stop;
            bad_zero = 0;
            bad_lr = 0;
            for (int b = 0; b < 64; b++) begin
                if (b >= 1 && b <= SW) begin
                    l[SW-b] = bits[b];
                end else if (b >= 33 && b <= 32 + SW) begin
                    r[SW-(b-32)] = bits[b];
                end else if (bits[b] !== 1'b0) begin
                    bad_zero++;
                end
                if (lrs[b] !== ((b >= 32) ? 1'b1 : 1'b0)) bad_lr++;
            end
            chk("frame_left",             64'(l),        64'(e.l));
            chk("frame_right",            64'(r),        64'(e.r));
            chk("frame_pad_bits_zero",    64'(bad_zero), 64'd0);
            chk("frame_lrclk_pattern",    64'(bad_lr),   64'd0);
            chk("frame_bclk_pattern",     64'(bb),       64'd0);
            chk("frame_underrun_at_load", 64'(u0),       64'(e.under));
            chk("frame_underrun_other",   64'(uo),       64'd0);
        end
    endtask

    // Frame monitor: a frame starts when busy rises; bits are sampled mid-bit while bclk is high.
    initial begin : monitor
        logic        mon_active;
        logic        busy_prev;
        logic        u_at0;
        logic        cur_stop;
        int          k;
        int          u_other;
        int          bad_bclk;
        logic [63:0] bits_s;
        logic [63:0] lrs_s;
        mon_active = 1'b0;
        busy_prev  = 1'b0;
        u_at0      = 1'b0;
        cur_stop   = 1'b0;
        k          = 0;
        u_other    = 0;
        bad_bclk   = 0;
        bits_s     = '0;
        lrs_s      = '0;
        forever begin
            @(negedge clk);
            if (reset === 1'b1) begin
                mon_active = 1'b0;
                busy_prev  = 1'b0;
            end else begin
                if (!mon_active && busy === 1'b1 && !busy_prev) begin
                    mon_active = 1'b1;
                    k = 0;
                    u_at0 = 1'b0;
                    u_other = 0;
                    bad_bclk = 0;
                end
                busy_prev = (busy === 1'b1);
                if (mon_active) begin
                    if ((k % DIV) == DIV / 2) begin
                        bits_s[k/DIV] = sdata;
                        lrs_s[k/DIV]  = lrclk;
                    end
                    if (bclk !== (((k % DIV) >= DIV / 2) ? 1'b1 : 1'b0)) bad_bclk++;
                    if (underrun === 1'b1) begin
                        if (k == 0) u_at0 = 1'b1;
                        else u_other++;
                    end
                    k++;
                    if (k == FRAME_CLKS) begin
                        check_frame(bits_s, lrs_s, u_at0, u_other, bad_bclk, cur_stop);
                        k = 0;
                        u_at0 = 1'b0;
                        u_other = 0;
                        bad_bclk = 0;
                        if (cur_stop) mon_active = 1'b0;
                    end
                end
            end
        end
    end

    initial begin : stimulus
        int acc;
        int load_cyc;
        tbl[0] = '{16'hA5A5, 16'h5A5A, 1'b1, 1'b0};
        tbl[1] = '{16'h1234, 16'hFEDC, 1'b1, 1'b0};
        tbl[2] = '{16'h0000, 16'h0000, 1'b0, 1'b0};
        tbl[3] = '{16'h8001, 16'h7FFE, 1'b1, 1'b0};
        tbl[4] = '{16'hFFFF, 16'h0000, 1'b1, 1'b1};

        reset        = 1'b1;
        enable       = 1'b1;
        sample_valid = 1'b0;
        sample_l     = '0;
        sample_r     = '0;
        last_l       = '0;
        last_r       = '0;

        // Reset held with enable high: everything quiet, ready high.
        tick(); tick(); tick();
        chk("reset_bclk",         64'(bclk),         64'd0);
        chk("reset_lrclk",        64'(lrclk),        64'd0);
        chk("reset_sdata",        64'(sdata),        64'd0);
        chk("reset_underrun",     64'(underrun),     64'd0);
        chk("reset_busy",         64'(busy),         64'd0);
        chk("reset_sample_ready", 64'(sample_ready), 64'd1);

        // Release: first frame has no sample, so it underruns with zeros; stop at bit 10.
        push_exp('0, '0, 1'b1, 1'b1);
        reset = 1'b0;
        tick();
        load_cyc = cyc;
        chk("release_busy_1clk", 64'(busy), 64'd1);
        wait_until(load_cyc + 10 * DIV);
        enable = 1'b0;
        wait_until(load_cyc + FRAME_CLKS);
        check_stop_idle("stop1");

        // Streaming from the vector table, with back-to-back presentation of the first two pairs.
        send(tbl[0].l, tbl[0].r, acc);
        push_exp(tbl[0].l, tbl[0].r, 1'b0, tbl[0].stop);
        last_l = tbl[0].l;
        last_r = tbl[0].r;
        enable = 1'b1;
        load_cyc = cyc + 1;
        send(tbl[1].l, tbl[1].r, acc);
        chk("backpressure_accept_cycle", 64'(acc - load_cyc), 64'd1);
        push_exp(tbl[1].l, tbl[1].r, 1'b0, tbl[1].stop);
        last_l = tbl[1].l;
        last_r = tbl[1].r;
        for (int i = 2; i < NV; i++) begin
            wait_until(load_cyc + FRAME_CLKS * (i - 1));
            if (tbl[i].present) begin
                send(tbl[i].l, tbl[i].r, acc);
                chk("stream_accept_cycle", 64'(acc - (load_cyc + FRAME_CLKS * (i - 1))), 64'd1);
                push_exp(tbl[i].l, tbl[i].r, 1'b0, tbl[i].stop);
                last_l = tbl[i].l;
                last_r = tbl[i].r;
            end else begin
                push_exp(REPEAT ? last_l : '0, REPEAT ? last_r : '0, 1'b1, tbl[i].stop);
            end
        end
        wait_until(load_cyc + FRAME_CLKS * (NV - 1) + 8);
        enable = 1'b0;
        wait_until(load_cyc + FRAME_CLKS * NV);
        check_stop_idle("stop2");

        // Reset in the middle of bit 40 with a second sample sitting in the holding register.
        send(16'h3C3C, 16'hC3C3, acc);
        push_exp(16'h3C3C, 16'hC3C3, 1'b0, 1'b1);
        enable = 1'b1;
        tick();
        load_cyc = cyc;
        send(16'h0F0F, 16'hF0F0, acc);
        wait_until(load_cyc + 40 * DIV);
        #2;
        reset = 1'b1;
        #1;
        chk("abort_bclk",         64'(bclk),         64'd0);
        chk("abort_lrclk",        64'(lrclk),        64'd0);
        chk("abort_sdata",        64'(sdata),        64'd0);
        chk("abort_busy",         64'(busy),         64'd0);
        chk("abort_underrun",     64'(underrun),     64'd0);
        chk("abort_sample_ready", 64'(sample_ready), 64'd1);
        exp_q.delete();
        last_l = '0;
        last_r = '0;
        // Held pair was discarded, so the restarted frame underruns from bit 0.
        push_exp('0, '0, 1'b1, 1'b1);
        tick();
        reset = 1'b0;
        tick();
        load_cyc = cyc;
        chk("restart_busy", 64'(busy), 64'd1);
        wait_until(load_cyc + 10 * DIV);
        enable = 1'b0;
        wait_until(load_cyc + FRAME_CLKS);
        check_stop_idle("stop3");

        tick();
        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
